// File: rtl/mem_sram_stage.sv
// Memory stage front end for an external 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low and a high half-word phase of
// WAIT_CYCLES clocks each, followed by a single DONE cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access in flight; a request is latched and starts LO
//   LO    | low half-word phase (sram_addr LSB = 0, data[15:0])
//   HI    | high half-word phase (sram_addr LSB = 1, data[31:16])
//   DONE  | one-cycle completion, ready high, requests not sampled
module mem_sram_stage #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] val_rm,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        op_wr;
  logic [31:0] phys;
  logic [31:0] data;
  logic        req;
  logic        last;

  // Only the word-address bits of the physical address reach the SRAM.
  logic unused_phys;
  assign unused_phys = ^{phys[31:19], phys[1:0]};

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == LAST);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Latch the operation, physical address and store data when an access starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr <= 1'b0;
      phys  <= 32'd0;
      data  <= 32'd0;
    end else if (state == IDLE && req) begin
      op_wr <= mem_w_en;
      phys  <= alu_res - BASE_ADDR;
      data  <= val_rm;
    end
  end

  // Capture read data on the last cycle of each phase; hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (!op_wr && last) begin
      if (state == LO) rdata[15:0]  <= sram_dq_in;
      if (state == HI) rdata[31:16] <= sram_dq_in;
    end
  end

  // Next-state and wait-counter sequencing.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LO;
          cnt_nxt   = 4'd0;
        end
      end
      LO: begin
        if (last) begin
          state_nxt = HI;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pin drive and pipeline handshake, decoded from the current state.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = !req;
      LO: begin
        sram_addr = {phys[18:2], 1'b0};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = data[15:0];
          sram_we_n   = last;
        end
      end
      HI: begin
        sram_addr = {phys[18:2], 1'b1};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = data[31:16];
          sram_we_n   = last;
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_sram_stage.sv
// Bench for mem_sram_stage: directed vector table, back-to-back and reset
// sequences, then random loads/stores against a transaction-level model.
module tb_mem_sram_stage;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm;
  logic        ready;
  logic [31:0] rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sram_mem [0:255];
  logic [15:0] ref_mem  [0:255];
  logic [31:0] ref_rdata;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] alu;
    logic [31:0] val;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  mem_sram_stage #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .alu_res     (alu_res),
    .val_rm      (val_rm),
    .ready       (ready),
    .rdata       (rdata),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // Simple SRAM: write while we_n is low, asynchronous read.
  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: applies a load/store to the reference memory.
  task automatic ref_apply(input logic r, input logic w, input logic [31:0] alu, input logic [31:0] val);
    logic [31:0] p;
    logic [7:0]  lo_i, hi_i;
    p    = alu - BASE;
    lo_i = {p[8:2], 1'b0};
    hi_i = {p[8:2], 1'b1};
    if (w) begin
      ref_mem[lo_i] = val[15:0];
      ref_mem[hi_i] = val[31:16];
    end else if (r) begin
      ref_rdata = {ref_mem[hi_i], ref_mem[lo_i]};
    end
  endtask

  // Holds the request for a whole access (frozen pipeline) and checks every cycle.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] alu,
                         input logic [31:0] val, input logic [31:0] exp_rd);
    logic [31:0] p;
    logic [16:0] hw;
    logic        e_ready, e_we_n, e_oe;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    int          i;
    p        = alu - BASE;
    hw       = p[18:2];
    mem_r_en = r;
    mem_w_en = w;
    alu_res  = alu;
    val_rm   = val;
    for (int k = 0; k <= 2*W+1; k++) begin
      e_ready = (k == 2*W+1);
      e_addr  = 18'd0;
      e_dq    = 16'd0;
      e_oe    = 1'b0;
      e_we_n  = 1'b1;
      if (k >= 1 && k <= 2*W) begin
        i      = (k <= W) ? k - 1 : k - W - 1;
        e_addr = {hw, (k > W)};
        if (w) begin
          e_oe   = 1'b1;
          e_dq   = (k <= W) ? val[15:0] : val[31:16];
          e_we_n = (i == W-1);
        end
      end
      @(negedge clk);
      chk("ready",     {31'd0, ready},      {31'd0, e_ready});
      chk("sram_addr", {14'd0, sram_addr},  {14'd0, e_addr});
      chk("we_n",      {31'd0, sram_we_n},  {31'd0, e_we_n});
      chk("dq_oe",     {31'd0, sram_dq_oe}, {31'd0, e_oe});
      chk("dq_out",    {16'd0, sram_dq_out}, {16'd0, e_dq});
      if (k == 2*W+1) chk("rdata", rdata, exp_rd);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, ready},     32'd1);
      chk("idle_we_n",  {31'd0, sram_we_n}, 32'd1);
      chk("idle_addr",  {14'd0, sram_addr}, 32'd0);
      chk("idle_oe",    {31'd0, sram_dq_oe}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic        rr, ww;
    logic [31:0] a, v;

    for (int n = 0; n < 256; n++) begin
      sram_mem[n] = 16'd0;
      ref_mem[n]  = 16'd0;
    end
    ref_rdata = 32'd0;

    tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678};
    tbl[4] = '{1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, 32'h12345678};
    tbl[5] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hA5A55A5A};
    tbl[6] = '{1'b1, 1'b0, 32'd1031, 32'h0,        32'h12345678};
    tbl[7] = '{1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 32'h12345678};
    tbl[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h0BADF00D};
    tbl[9] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hA5A55A5A};

    rst      = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = 32'd0;
    val_rm   = 32'd0;
    #1;
    chk("rst_we_n",  {31'd0, sram_we_n},  32'd1);
    chk("rst_oe",    {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_addr",  {14'd0, sram_addr},  32'd0);
    chk("rst_dq",    {16'd0, sram_dq_out}, 32'd0);
    chk("rst_rdata", rdata,               32'd0);
    chk("rst_ready", {31'd0, ready},      32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // Directed vector table.
    for (int t = 0; t < 10; t++) begin
      ref_apply(tbl[t].r, tbl[t].w, tbl[t].alu, tbl[t].val);
      run_txn(tbl[t].r, tbl[t].w, tbl[t].alu, tbl[t].val, tbl[t].exp_rdata);
      idle_cycles(1);
    end

    // Back-to-back loads with the request held: ready at cycles 11 and 23.
    ref_apply(1'b1, 1'b0, 32'd1024, 32'd0);
    run_txn(1'b1, 1'b0, 32'd1024, 32'd0, ref_rdata);
    ref_apply(1'b1, 1'b0, 32'd1020, 32'd0);
    run_txn(1'b1, 1'b0, 32'd1020, 32'd0, ref_rdata);

    // Long idle stretch.
    idle_cycles(20);

    // Random loads/stores against the model.
    for (int t = 0; t < 25; t++) begin
      rr = 1'($urandom_range(0, 1));
      ww = 1'($urandom_range(0, 1));
      if (!rr && !ww) rr = 1'b1;
      a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      v = $urandom;
      ref_apply(rr, ww, a, v);
      run_txn(rr, ww, a, v, ref_rdata);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in cycle 3 of a store abandons the access.
    mem_w_en = 1'b1;
    mem_r_en = 1'b0;
    alu_res  = 32'd1028;
    val_rm   = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    mem_w_en = 1'b0;
    rst      = 1'b0;
    #1;
    chk("mid_rst_we_n",  {31'd0, sram_we_n},  32'd1);
    chk("mid_rst_oe",    {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_rst_addr",  {14'd0, sram_addr},  32'd0);
    chk("mid_rst_dq",    {16'd0, sram_dq_out}, 32'd0);
    chk("mid_rst_rdata", rdata,               32'd0);
    chk("mid_rst_ready", {31'd0, ready},      32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(6);
    // Only the low half was strobed (two write cycles) before reset.
    ref_mem[8'd2] = 16'hF00D;
    ref_rdata     = 32'd0;
    ref_apply(1'b1, 1'b0, 32'd1028, 32'd0);
    run_txn(1'b1, 1'b0, 32'd1028, 32'd0, ref_rdata);
    idle_cycles(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_sram_stage.md
MEM_SRAM_STAGE -- requirements
Module: mem_sram_stage

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: clock cycles per SRAM half-word phase; legal range 2..15.
REQ-002 Parameter BASE_ADDR, default 32'd1024: data-memory base subtracted from the ALU address.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_r_en  input  1  load request from the execute stage.
REQ-006 mem_w_en  input  1  store request from the execute stage.
REQ-007 alu_res  input  32  byte address of the access, as computed by the execute stage.
REQ-008 val_rm  input  32  store data.
REQ-009 ready  output  1  high means the stage is not stalling; low freezes the pipeline.
REQ-010 rdata  output  32  load result.
REQ-011 sram_addr  output  18  half-word address to the external SRAM.
REQ-012 sram_dq_out  output  16  write data to the SRAM.
REQ-013 sram_dq_in  input  16  read data from the SRAM.
REQ-014 sram_dq_oe  output  1  drive enable for the bidirectional data pins.
REQ-015 sram_we_n  output  1  active-low SRAM write enable.

Function
REQ-016 The block SHALL be a 4-state FSM: IDLE, LO, HI, DONE.
REQ-017 In IDLE with (mem_r_en | mem_w_en) = 1:
  - latch op (write if mem_w_en = 1, else read), phys = alu_res - BASE_ADDR (32-bit wrap) and val_rm;
  - load wait counter = 0;
  - go to LO.
REQ-018 If mem_r_en and mem_w_en are both 1, the block SHALL perform a write only.
REQ-019 In IDLE with no request, the block SHALL stay in IDLE.
REQ-020 LO and HI SHALL each last exactly WAIT_CYCLES cycles:
  - the counter increments each cycle;
  - on count = WAIT_CYCLES-1 the counter clears and LO goes to HI, HI goes to DONE.
REQ-021 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; requests are not sampled in DONE.
REQ-022 sram_addr SHALL be {phys[18:2], 1'b0} in LO, {phys[18:2], 1'b1} in HI, and 18'd0 in IDLE/DONE; phys[1:0] is ignored (word aligned).
REQ-023 Write op, data pins:
  - sram_dq_oe = 1 throughout LO and HI;
  - sram_dq_out = data[15:0] in LO and data[31:16] in HI.
REQ-024 Write op, sram_we_n SHALL be 0 on every LO/HI cycle except the last cycle of each phase (count = WAIT_CYCLES-1), which gives address/data hold.
REQ-025 sram_we_n SHALL be 1, sram_dq_oe 0 and sram_dq_out 16'd0 at all other times.
REQ-026 Read op, sram_dq_in SHALL be captured on the last cycle of each phase:
  - LO capture goes into rdata[15:0];
  - HI capture goes into rdata[31:16].
REQ-027 rdata SHALL hold its value at all other times, including across writes.
REQ-028 ready SHALL be combinational:
  - 1 in DONE;
  - 1 in IDLE when no request is present;
  - 0 otherwise, including the IDLE cycle in which a request is first seen.
REQ-029 Latency: request present in IDLE at cycle 0 -> ready = 1 in cycle 2*WAIT_CYCLES+1 (cycle 11 at default).
REQ-030 Back-to-back requests: a request present on the cycle after DONE SHALL start a new access from IDLE with no extra idle cycle.

Reset
REQ-031 When rst = 0 the block SHALL immediately, independent of clk:
  - enter IDLE, clear the wait counter, latched address, latched data and rdata;
  - drive sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
REQ-032 Reset asserted mid-access SHALL abandon the access; no further SRAM write strobe may occur.
REQ-033 After reset releases, ready SHALL reflect the IDLE rule of REQ-028.

Verification
REQ-034 Store, default parameters:
  - stimulus: mem_w_en = 1, alu_res = 1028, val_rm = 32'hDEADBEEF;
  - response: sram_addr = 2 in LO with dq_out = BEEF; sram_addr = 3 in HI with dq_out = DEAD;
  - response: we_n low 4 cycles per phase; ready = 1 only at cycle 11.
REQ-035 Load at alu_res = 1028 with the SRAM model returning BEEF at addr 2 and DEAD at addr 3 -> rdata = 32'hDEADBEEF while ready = 1 at cycle 11.
REQ-036 mem_r_en = mem_w_en = 1 -> write sequence only, and rdata is unchanged.
REQ-037 Two consecutive loads held by a frozen pipeline -> second access starts on the cycle after DONE; ready pulses high at cycles 11 and 23.
REQ-038 rst driven low at cycle 3 of a store:
  - immediately: we_n = 1, oe = 0, state IDLE;
  - after release with no request: ready = 1 and no SRAM activity.
REQ-039 Idle with no request for 20 cycles -> ready held at 1, we_n held at 1, sram_addr held at 0.
